i2c_master: RTL and testbench

Single-master I2C initiator that executes register-pointer transactions against the team's `I2C_Slave` register block (default address 0x54). A transaction is started with one command pulse. Every transaction, read or write, sends START, then address+R/W, then one register-pointer byte, then 0–4 data bytes, then STOP. The block sits between the AXI/CPU command register file and the board-level SCL/SDA pins.

---
 rtl/i2c_master.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_master.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// i2c_master : single-master I2C initiator for register-pointer transactions
// Rev 1.0
// ============================================================================
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [6:0]  iSlaveAddr,
  input  logic        iRW,
  input  logic [7:0]  iRegAddr,
  input  logic [2:0]  iLen,
  input  logic [31:0] iWData,
  output logic [31:0] oRData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oAckErr,
  output logic        oSCL,
  inout  wire         ioSDA
);

  localparam int CW = $clog2(CLK_DIV);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_REG      = 4'd4;
  localparam logic [3:0] S_REG_ACK  = 4'd5;
  localparam logic [3:0] S_WDATA    = 4'd6;
  localparam logic [3:0] S_WACK     = 4'd7;
  localparam logic [3:0] S_RDATA    = 4'd8;
  localparam logic [3:0] S_RACK     = 4'd9;
  localparam logic [3:0] S_STOP     = 4'd10;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic          ack_q, ack_d;
  logic [6:0]    addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [7:0]    reg_q, reg_d;
  logic [2:0]    len_q, len_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          busy_q, busy_d, done_q, done_d, ackerr_q, ackerr_d;
  logic          scl_q, scl_d, sda_oe_q, sda_oe_d;
  logic          tick, more;
  logic [7:0]    tx_byte;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));
  // After REG_ACK "more" means any data at all; after a data byte it means another one follows.
  assign more = (state_q == S_REG_ACK) ? (len_q != 3'd0)
                                       : (({1'b0, byte_q} + 3'd1) != len_q);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;  cnt_q    <= '0;     qtr_q   <= '0;
      bit_q    <= 3'd7;    byte_q   <= '0;     shift_q <= '0;
      ack_q    <= 1'b0;    addr_q   <= '0;     rw_q    <= 1'b0;
      reg_q    <= '0;      len_q    <= '0;     wdata_q <= '0;
      rdata_q  <= '0;      busy_q   <= 1'b0;   done_q  <= 1'b0;
      ackerr_q <= 1'b0;    scl_q    <= 1'b1;   sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;  cnt_q    <= cnt_d;    qtr_q   <= qtr_d;
      bit_q    <= bit_d;    byte_q   <= byte_d;   shift_q <= shift_d;
      ack_q    <= ack_d;    addr_q   <= addr_d;   rw_q    <= rw_d;
      reg_q    <= reg_d;    len_q    <= len_d;    wdata_q <= wdata_d;
      rdata_q  <= rdata_d;  busy_q   <= busy_d;   done_q  <= done_d;
      ackerr_q <= ackerr_d; scl_q    <= scl_d;    sda_oe_q <= sda_oe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == S_IDLE || tick) ? '0 : cnt_q + 1'b1;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    ack_d    = ack_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    reg_d    = reg_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    ackerr_d = ackerr_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart && !done_q) begin
          addr_d   = iSlaveAddr;
          rw_d     = iRW;
          reg_d    = iRegAddr;
          len_d    = (iLen > 3'd4) ? 3'd4 : iLen;
          wdata_d  = iWData;
          ackerr_d = 1'b0;
          busy_d   = 1'b1;
          qtr_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: if (tick) begin
        if (qtr_q == 2'd1) begin
          qtr_d   = '0;
          bit_d   = 3'd7;
          state_d = S_ADDR;
        end else begin
          qtr_d = qtr_q + 2'd1;
        end
      end
      S_STOP: if (tick) begin
        if (qtr_q == 2'd2) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          qtr_d = qtr_q + 2'd1;
        end
      end
      default: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd2) begin
          if (state_q == S_RDATA) shift_d = {shift_q[6:0], ioSDA};
          else                    ack_d   = ioSDA;
        end
        if (qtr_q == 2'd3) begin
          case (state_q)
            S_ADDR, S_REG, S_WDATA, S_RDATA: begin
              bit_d = bit_q - 3'd1;
              if (bit_q == 3'd0) begin
                case (state_q)
                  S_ADDR:  state_d = S_ADDR_ACK;
                  S_REG:   state_d = S_REG_ACK;
                  S_WDATA: state_d = S_WACK;
                  default: begin
                    rdata_d[{byte_q, 3'b000} +: 8] = shift_q;
                    state_d = S_RACK;
                  end
                endcase
              end
            end
            S_RACK: begin
              bit_d = 3'd7;
              if (more) begin
                byte_d  = byte_q + 2'd1;
                state_d = S_RDATA;
              end else begin
                state_d = S_STOP;
              end
            end
            default: begin
              bit_d = 3'd7;
              if (ack_q) begin
                ackerr_d = 1'b1;
                state_d  = S_STOP;
              end else if (state_q == S_ADDR_ACK) begin
                state_d = S_REG;
              end else if (!more) begin
                state_d = S_STOP;
              end else if (state_q == S_REG_ACK) begin
                byte_d  = '0;
                state_d = rw_q ? S_RDATA : S_WDATA;
              end else begin
                byte_d  = byte_q + 2'd1;
                state_d = S_WDATA;
              end
            end
          endcase
        end
      end
    endcase
  end

  // Pin levels are derived from the next state so the registered pins line up with each quarter.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    tx_byte  = 8'h00;
    case (state_d)
      S_ADDR:  tx_byte = {addr_q, rw_q};
      S_REG:   tx_byte = reg_q;
      S_WDATA: tx_byte = wdata_q[{byte_d, 3'b000} +: 8];
      default: tx_byte = 8'h00;
    endcase
    case (state_d)
      S_START: sda_oe_d = 1'b1;
      S_ADDR, S_REG, S_WDATA: begin
        scl_d    = qtr_d[1];
        sda_oe_d = ~tx_byte[bit_d];
      end
      S_ADDR_ACK, S_REG_ACK, S_WACK, S_RDATA: scl_d = qtr_d[1];
      S_RACK: begin
        scl_d    = qtr_d[1];
        sda_oe_d = (({1'b0, byte_d} + 3'd1) != len_q);
      end
      S_STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: ;
    endcase
  end

  assign oRData  = rdata_q;
  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oAckErr = ackerr_q;
  assign oSCL    = scl_q;
  assign ioSDA   = sda_oe_q ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
// tb_i2c_master : i2c_master against a behavioural register-block slave (0x54)
// Rev 1.0
// ============================================================================
module tb_i2c_master;
  localparam int         CLK_DIV = 6;
  localparam logic [6:0] SLV     = 7'h54;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  saddr = '0;
  logic        rw = 1'b0;
  logic [7:0]  regaddr = '0;
  logic [2:0]  len = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, ackerr, scl;
  wire         sda;
  logic        sl_drive = 1'b0;

  pullup (sda);
  assign sda = sl_drive ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iSlaveAddr(saddr), .iRW(rw),
    .iRegAddr(regaddr), .iLen(len), .iWData(wdata), .oRData(rdata),
    .oBusy(busy), .oDone(done), .oAckErr(ackerr), .oSCL(scl), .ioSDA(sda)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Slave state and bus event counters
  int         sl_mode = 0;   // 0 idle, 1 receiving, 2 transmitting
  int         sl_byte = 0, sl_bits = 0;
  int         n_start = 0, n_stop = 0, n_rise = 0, sl_macks = 0, sl_mnacks = 0;
  logic       sl_ackslot = 1'b0, sl_read = 1'b0, sl_mnack = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] sl_sh = '0, sl_ptr = '0;
  logic [7:0] sl_mem [256];

  // Reference model
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sl_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_scl && scl && prev_sda && !sda) begin
        n_start++;
        sl_mode = 1; sl_byte = 0; sl_bits = 0; sl_ackslot = 1'b0; sl_drive = 1'b0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        n_stop++;
        sl_mode = 0; sl_drive = 1'b0;
      end else if (!prev_scl && scl) begin
        n_rise++;
        if (sl_mode == 1 && !sl_ackslot) begin
          sl_sh = {sl_sh[6:0], sda};
          sl_bits++;
        end else if (sl_mode == 2 && sl_ackslot) begin
          sl_mnack = sda;
          if (sda) sl_mnacks++; else sl_macks++;
        end
      end else if (prev_scl && !scl) begin
        if (sl_mode == 1) begin
          if (sl_ackslot) begin
            sl_ackslot = 1'b0; sl_drive = 1'b0; sl_bits = 0; sl_byte++;
            if (sl_byte == 2 && sl_read) begin
              sl_mode = 2; sl_sh = sl_mem[sl_ptr]; sl_drive = !sl_sh[7]; sl_bits = 1;
            end
          end else if (sl_bits == 8) begin
            if (sl_byte == 0) begin
              if (sl_sh[7:1] == SLV) begin
                sl_read = sl_sh[0]; sl_ackslot = 1'b1; sl_drive = 1'b1;
              end else begin
                sl_mode = 0;
              end
            end else begin
              if (sl_byte == 1) sl_ptr = sl_sh;
              else              sl_mem[sl_ptr] = sl_sh;
              sl_ackslot = 1'b1; sl_drive = 1'b1;
            end
          end
        end else if (sl_mode == 2) begin
          if (sl_ackslot) begin
            sl_ackslot = 1'b0;
            if (sl_mnack) begin
              sl_mode = 0; sl_drive = 1'b0;
            end else begin
              sl_sh = sl_mem[sl_ptr]; sl_drive = !sl_sh[7]; sl_bits = 1;
            end
          end else if (sl_bits == 8) begin
            sl_drive = 1'b0; sl_ackslot = 1'b1;
          end else begin
            sl_drive = !sl_sh[3'(7 - sl_bits)];
            sl_bits++;
          end
        end
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  // One full transaction, entered and left on a falling clock edge.
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] p,
                         input logic [2:0] l, input logic [31:0] wd, input logic xs);
    int n, q, cyc, limit, s0, p0, r0, m0, k0;
    logic ok;
    logic [31:0] exp_rd;
    n  = (l > 3'd4) ? 4 : int'(l);
    ok = (a == SLV);
    q  = ok ? (2 + 36 * (2 + n) + 3) : 41;
    exp_rd = ref_rd;
    if (ok) begin
      if (!r && n > 0) ref_mem[p] = wd[8 * (n - 1) +: 8];
      if (r) for (int k = 0; k < n; k++) exp_rd[8 * k +: 8] = ref_mem[p];
    end
    s0 = n_start; p0 = n_stop; r0 = n_rise; m0 = sl_macks; k0 = sl_mnacks;

    saddr = a; rw = r; regaddr = p; len = l; wdata = wd; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("cyc1_busy", busy, 1);
    check("cyc1_sda", sda, 0);
    check("cyc1_scl", scl, 1);

    cyc = 0;
    limit = q * CLK_DIV + 200;
    while (!done && cyc < limit) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (xs && cyc == 40) start = 1'b1;
      if (xs && cyc == 41) start = 1'b0;
    end
    check("done_cycles", cyc, q * CLK_DIV);
    check("ackerr", ackerr, {31'b0, !ok});
    check("rdata", rdata, exp_rd);
    ref_rd = exp_rd;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_after_done", busy, 0);
    check("start_count", n_start - s0, 1);
    check("stop_count", n_stop - p0, 1);
    check("scl_rises", n_rise - r0, ok ? 9 * (2 + n) + 1 : 10);
    if (ok && r)
      check("master_ack_pattern", ((sl_macks - m0) << 8) | (sl_mnacks - k0), ((n - 1) << 8) | 1);
    check("slave_reg", sl_mem[p], ref_mem[p]);
  endtask

  initial begin
    int t;
    logic [6:0]  a;
    logic        r;
    logic [2:0]  l;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ackerr", ackerr, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(SLV,   1'b0, 8'h01, 3'd1, 32'h0000_00A5, 1'b0);
    run_txn(SLV,   1'b1, 8'h01, 3'd1, 32'h0,         1'b0);
    run_txn(7'h55, 1'b0, 8'h01, 3'd1, 32'h0000_00C3, 1'b0);
    run_txn(SLV,   1'b0, 8'h02, 3'd2, 32'h0000_2211, 1'b0);
    run_txn(SLV,   1'b1, 8'h02, 3'd3, 32'h0,         1'b0);
    run_txn(SLV,   1'b0, 8'h03, 3'd0, 32'h0000_0077, 1'b1);
    run_txn(SLV,   1'b0, 8'h04, 3'd7, 32'hDEAD_BEEF, 1'b0);

    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : SLV;
      r = 1'($urandom_range(0, 1));
      l = 3'($urandom_range(0, 7));
      if (r && l == 3'd0) l = 3'd1;
      run_txn(a, r, 8'($urandom_range(0, 7)), l, $urandom, 1'($urandom_range(0, 1)));
    end

    // Abort a read mid-byte with an all-ones register so the slave leaves SDA released.
    run_txn(SLV, 1'b0, 8'h07, 3'd1, 32'h0000_00FF, 1'b0);
    saddr = SLV; rw = 1'b1; regaddr = 8'h07; len = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(sl_mode == 2 && sl_bits == 5) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("rst_reach_rdata", {31'b0, t < 5000}, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_scl", scl, 1);
    check("midrst_sda", sda, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_rd = '0;
    @(negedge clk);
    run_txn(SLV, 1'b0, 8'h00, 3'd1, 32'h0000_005A, 1'b0);
    run_txn(SLV, 1'b1, 8'h00, 3'd1, 32'h0,         1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
